// File: rtl/alu_32.sv
// 32-bit MIPS-style ALU with integrated ALU-control decoder.
// Result, zero and overflow flags are registered once per clock.
module alu_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  aluop,
  input  logic [3:0]  funct,
  output logic [2:0]  gin,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_NUL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  alu_op_t     sel;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_add;
  logic        ovf_sub;
  logic [31:0] alu_res;
  logic        alu_ovf;

  // Reserved aluop 11 and unlisted R-type funct codes fall back to ADD.
  always_comb begin
    sel = OP_ADD;
    unique case (aluop)
      2'b00: sel = OP_ADD;
      2'b01: sel = OP_SUB;
      2'b10: begin
        case (funct)
          4'b0000: sel = OP_ADD;
          4'b0010: sel = OP_SUB;
          4'b0100: sel = OP_AND;
          4'b0101: sel = OP_OR;
          4'b0110: sel = OP_XOR;
          4'b0111: sel = OP_NOR;
          4'b1010: sel = OP_SLT;
          default: sel = OP_ADD;
        endcase
      end
      default: sel = OP_ADD;
    endcase
  end

  assign gin = sel;

  assign sum     = a + b;
  assign diff    = a + ~b + 32'd1;
  assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
  assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);

  // SLT uses sign-of-difference corrected by overflow to stay exact at the range ends.
  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (sel)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      OP_SLT: alu_res = {31'd0, diff[31] ^ ovf_sub};
      default: alu_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 32'd0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      result <= alu_res;
      zero   <= (alu_res == 32'd0);
      ovf    <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32: decode, arithmetic, logic,
// overflow/SLT boundaries and asynchronous reset behaviour.
module tb_alu_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [2:0]  gin;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int vec_count;
  int miscompares;

  alu_32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .aluop  (aluop),
    .funct  (funct),
    .gin    (gin),
    .result (result),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then sample just after the capturing edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] fn,
                               input logic [31:0] av, input logic [31:0] bv);
    aluop = op;
    funct = fn;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input string tag, input logic [1:0] op, input logic [3:0] fn,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_res, input logic exp_zero,
                           input logic exp_ovf);
    applyStimulus(op, fn, av, bv);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] fn;
    logic [2:0] exp_gin;
  } dec_vec_t;

  dec_vec_t dec_tab[10];

  initial begin
    vec_count   = 0;
    miscompares = 0;
    rst_n = 1'b1;
    aluop = 2'($urandom);
    funct = 4'($urandom);
    a     = $urandom;
    b     = $urandom;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_result", result, 32'd0);
    checkOutput("rst_async_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_async_ovf", {31'd0, ovf}, 32'd0);

    // Registers must hold reset values across edges with random inputs.
    repeat (3) begin
      @(negedge clk);
      a = $urandom | 32'h1;
      b = $urandom;
      aluop = 2'b10;
      funct = 4'b0000;
    end
    @(posedge clk); #1;
    checkOutput("rst_hold_result", result, 32'd0);
    checkOutput("rst_hold_zero", {31'd0, zero}, 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    runVector("first_add", 2'b10, 4'b0000, 32'd50, 32'd100, 32'd150, 1'b0, 1'b0);
    checkOutput("first_add_gin", {29'd0, gin}, 32'd2);

    runVector("add_zero", 2'b10, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    runVector("add_neg", 2'b10, 4'b0000, 32'hFFFFFFFB, 32'hFFFFFFF6,
              32'hFFFFFFF1, 1'b0, 1'b0);

    // Inputs changing between edges must not disturb registered outputs.
    a = 32'h12345678;
    b = 32'h11111111;
    #3;
    checkOutput("hold_between_edges", result, 32'hFFFFFFF1);

    // Decode sweep on gin (combinational).
    dec_tab[0] = '{2'b00, 4'b1010, 3'b010};
    dec_tab[1] = '{2'b01, 4'b0000, 3'b110};
    dec_tab[2] = '{2'b11, 4'b0010, 3'b010};
    dec_tab[3] = '{2'b10, 4'b0010, 3'b110};
    dec_tab[4] = '{2'b10, 4'b0100, 3'b000};
    dec_tab[5] = '{2'b10, 4'b0101, 3'b001};
    dec_tab[6] = '{2'b10, 4'b0110, 3'b011};
    dec_tab[7] = '{2'b10, 4'b0111, 3'b100};
    dec_tab[8] = '{2'b10, 4'b1010, 3'b111};
    dec_tab[9] = '{2'b10, 4'b1111, 3'b010};
    for (int i = 0; i < 10; i++) begin
      aluop = dec_tab[i].op;
      funct = dec_tab[i].fn;
      #1;
      checkOutput($sformatf("decode_%0d", i), {29'd0, gin}, {29'd0, dec_tab[i].exp_gin});
    end

    // Logic operations.
    runVector("and", 2'b10, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
    runVector("or",  2'b10, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
    runVector("xor", 2'b10, 4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0);
    runVector("nor", 2'b10, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0);

    // Overflow and SLT boundaries.
    runVector("add_ovf", 2'b10, 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
    runVector("sub_ovf", 2'b10, 4'b0010, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    runVector("sub_plain", 2'b10, 4'b0010, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    runVector("slt_min", 2'b10, 4'b1010, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0);
    runVector("slt_rev", 2'b10, 4'b1010, 32'd1, 32'h80000000, 32'd0, 1'b1, 1'b0);
    runVector("slt_eq", 2'b10, 4'b1010, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    runVector("lw_add", 2'b00, 4'b1111, 32'd20, 32'hFFFFFFFC, 32'd16, 1'b0, 1'b0);

    // beq-style compare, then mid-stream reset.
    runVector("beq", 2'b01, 4'b0000, 32'd1234, 32'd1234, 32'd0, 1'b1, 1'b0);
    runVector("pre_rst", 2'b10, 4'b0000, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0);
    a = 32'h7FFFFFFF;
    b = 32'd1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_result", result, 32'd0);
    checkOutput("mid_rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    checkOutput("mid_rst_discard", result, 32'd0);
    checkOutput("mid_rst_discard_ovf", {31'd0, ovf}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
